// File: rtl/lvl_pulse_rx_pkg.sv
// Shared definitions for the level-to-pulse receiver: FSM state encoding,
// default parameter values and a small state classification helper.
package lvl_pulse_rx_pkg;

  // Fixed encodings; other blocks in the family decode these values directly.
  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_QUAL_LO = 2'd3
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_QUAL_CYC    = 20;
  localparam int unsigned DEF_CW          = 5;

  // True while a candidate edge is being timed.
  function automatic logic is_qual(input state_t st);
    return (st == ST_QUAL_HI) || (st == ST_QUAL_LO);
  endfunction

endpackage

// File: rtl/lvl_pulse_rx_sync_chain.sv
// Multi-flop synchroniser for one asynchronous level. Output s is the last
// stage; every stage clears to 0 on reset.
module lvl_pulse_rx_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s
);

  logic [STAGES-1:0] ff;

  // Shift the raw level through the chain; stage 0 is the metastable catcher.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign s = ff[STAGES-1];

endmodule

// File: rtl/lvl_pulse_rx.sv
// Level-to-pulse receiver: synchronises an asynchronous level, rejects
// glitches shorter than the qualification time and emits a one-clock pulse
// on each qualified rising and falling edge, gated by en.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_LOW     | qualified level is 0, waiting for s=1
// ST_QUAL_HI | s went high, timing it; any s=0 drops the candidate
// ST_HIGH    | qualified level is 1, waiting for s=0
// ST_QUAL_LO | s went low, timing it; any s=1 drops the candidate
module lvl_pulse_rx
  import lvl_pulse_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,  // >= 2
  parameter int QUAL_CYC    = DEF_QUAL_CYC,     // >= 1
  parameter int CW          = DEF_CW            // must hold QUAL_CYC-1
) (
  input  logic clk,
  input  logic reset,
  input  logic l,
  input  logic en,
  output logic q,
  output logic p_rise,
  output logic p_fall,
  output logic busy
);

  // Loading QUAL_CYC-1 and accepting on cnt==0 with s still matching means
  // QUAL_CYC+1 consecutive equal samples are needed for acceptance.
  localparam logic [CW-1:0] CNT_LOAD = CW'(QUAL_CYC - 1);

  logic          s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_d;
  logic          rise_d;
  logic          fall_d;
  logic          busy_d;

  lvl_pulse_rx_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (l),
    .s     (s)
  );

  // Next-state, counter and output decode; a mismatching s always wins over
  // counter expiry so a glitch in the final cycle is still rejected.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_QUAL_HI;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_QUAL_HI: begin
        if (!s) begin
          state_d = ST_LOW;
        end else if (cnt_q == '0) begin
          state_d = ST_HIGH;
          q_d     = 1'b1;
          rise_d  = en;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_QUAL_LO;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_QUAL_LO: begin
        if (s) begin
          state_d = ST_HIGH;
        end else if (cnt_q == '0) begin
          state_d = ST_LOW;
          q_d     = 1'b0;
          fall_d  = en;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
    busy_d = is_qual(state_d);
  end

  // Register state, counter and every output; reset aborts any qualification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      q       <= 1'b0;
      p_rise  <= 1'b0;
      p_fall  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q       <= q_d;
      p_rise  <= rise_d;
      p_fall  <= fall_d;
      busy    <= busy_d;
    end
  end

endmodule
